// File: rtl/mmio_uart_tx_if.sv
// Store/load bus seen by memory-mapped peripherals: the core drives the
// strobe, address and write data, and the peripheral answers with read data.
interface mmio_uart_tx_if;
    logic        mem_write;
    logic [31:0] data_addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (
        output mem_write,
        output data_addr,
        output wr_data,
        input  rd_data
    );

    modport slave (
        input  mem_write,
        input  data_addr,
        input  wr_data,
        output rd_data
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores to TXDATA are queued in a small
// FIFO and shifted out LSB first; STATUS reports FIFO state and drop count.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0200,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic           clk,
    input  logic           reset,
    mmio_uart_tx_if.slave  bus,
    output logic           tx_o,
    output logic           busy_o
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [31:0]       STATUS_ADDR = BASE_ADDR + 32'd4;
    localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;

    logic [7:0]        fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [7:0]        ovf_q, ovf_d;
    logic              busy_q, busy_d;

    logic              push_req;
    logic              clr_req;
    logic              accept;
    logic              pop;
    logic              baud_last;
    logic              fifo_empty;
    logic              fifo_full;
    logic              tx_active;
    logic [4:0]        count5;
    logic [7:0]        head;

    always_comb begin
        push_req   = bus.mem_write && (bus.data_addr == BASE_ADDR);
        clr_req    = bus.mem_write && (bus.data_addr == STATUS_ADDR) && bus.wr_data[0];
        baud_last  = (baud_q == BAUD_LAST);
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == DEPTH_C);
        head       = fifo_q[rd_ptr_q];
        tx_active  = (state_q != IDLE);
        count5     = 5'(count_q);
    end

    // Pop decision uses the pre-edge count, so a byte is never forwarded in
    // the same cycle it is written; a push into a full FIFO survives if a pop
    // frees the slot on the same edge.
    always_comb begin
        pop     = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && baud_last));
        accept  = push_req && (!fifo_full || pop);
        count_d = count_q + CNT_W'(accept) - CNT_W'(pop);
    end

    always_comb begin
        ovf_d = ovf_q;
        if (clr_req) begin
            ovf_d = 8'd0;
        end else if (push_req && !accept && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // The baud counter free-runs and wraps in every active state, so each
    // state simply acts on its last cycle.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_last ? '0 : baud_q + BAUD_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                if (pop) begin
                    state_d = START;
                    shift_d = head;
                end
            end
            START: begin
                if (baud_last) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (baud_last) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_last) begin
                    if (pop) begin
                        state_d = START;
                        shift_d = head;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_o = 1'b1;
        unique case (state_q)
            IDLE:    tx_o = 1'b1;
            START:   tx_o = 1'b0;
            DATA:    tx_o = shift_q[0];
            STOP:    tx_o = 1'b1;
            default: tx_o = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_q[wr_ptr_q] <= bus.wr_data[7:0];
        end
    end

    assign busy_d = (count_d != '0) || (state_d != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 8'd0;
            busy_q   <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_o = busy_q;

    always_comb begin
        bus.rd_data = 32'd0;
        if (bus.data_addr == STATUS_ADDR) begin
            bus.rd_data = {16'd0, ovf_q, count5, tx_active, fifo_empty, fifo_full};
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: fixed vectors, hand-written corner
// sequences and random bus traffic compared against a frame-level model.
module tb_mmio_uart_tx;

   localparam int          CPB   = 4;
   localparam int          DEPTH = 4;
   localparam int          FRAME = 10 * CPB;
   localparam logic [31:0] BASE  = 32'h0000_0200;
   localparam logic [31:0] STAT  = BASE + 32'd4;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic txLine;
   logic busyOut;

   int nVec = 0;
   int nBad = 0;

   // Reference model: a byte queue plus one "frame in flight" with a cycle
   // offset into its ten bit slots.
   logic [7:0] modelQ [$];
   bit         modelActive = 1'b0;
   int         modelT = 0;
   logic [7:0] modelCur = 8'h00;
   int         modelOvf = 0;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] data;
      logic        expTx;
      logic        expBusy;
      logic [31:0] expRd;
   } vec_t;

   vec_t tbl [8];

   mmio_uart_tx_if busIf();

   mmio_uart_tx #(
      .BASE_ADDR   (BASE),
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk   (clock),
      .reset (reset),
      .bus   (busIf),
      .tx_o  (txLine),
      .busy_o(busyOut)
   );

   always #5 clock = ~clock;

   function automatic logic expTxFn();
      int slot;
      if (!modelActive) return 1'b1;
      slot = modelT / CPB;
      if (slot == 0) return 1'b0;
      if (slot == 9) return 1'b1;
      return modelCur[slot-1];
   endfunction

   function automatic logic expBusyFn();
      return (modelQ.size() != 0) || modelActive;
   endfunction

   function automatic logic [31:0] expRdFn(input logic [31:0] addr);
      logic [31:0] r;
      r = 32'd0;
      if (addr == STAT) begin
         r[0]     = (modelQ.size() == DEPTH);
         r[1]     = (modelQ.size() == 0);
         r[2]     = modelActive;
         r[7:3]   = 5'(modelQ.size());
         r[15:8]  = 8'(modelOvf);
      end
      return r;
   endfunction

   task automatic modelClear();
      modelQ.delete();
      modelActive = 1'b0;
      modelT      = 0;
      modelOvf    = 0;
   endtask

   task automatic modelEdge(input bit we, input logic [31:0] addr, input logic [31:0] data);
      bit popNow;
      popNow = (modelQ.size() > 0) && (!modelActive || (modelT == FRAME - 1));
      if (popNow) modelCur = modelQ.pop_front();
      if (we && addr == BASE) begin
         if (modelQ.size() < DEPTH) modelQ.push_back(data[7:0]);
         else if (modelOvf < 255) modelOvf++;
      end
      if (we && addr == STAT && data[0]) modelOvf = 0;
      if (popNow) begin
         modelActive = 1'b1;
         modelT      = 0;
      end else if (modelActive) begin
         if (modelT == FRAME - 1) modelActive = 1'b0;
         else modelT++;
      end
   endtask

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nBad++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput();
      checkVal("tx", {31'd0, txLine}, {31'd0, expTxFn()});
      checkVal("busy", {31'd0, busyOut}, {31'd0, expBusyFn()});
      checkVal("rd_data", busIf.rd_data, expRdFn(busIf.data_addr));
   endtask

   // Drive one bus cycle just after a falling edge, advance the model on the
   // rising edge, then compare on the next falling edge.
   task automatic applyStimulus(input bit we, input logic [31:0] addr, input logic [31:0] data);
      busIf.mem_write = we;
      busIf.data_addr = addr;
      busIf.wr_data   = data;
      @(posedge clock);
      modelEdge(we, addr, data);
      @(negedge clock);
      checkOutput();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, STAT, 32'd0);
   endtask

   task automatic drain(input string name, input int bound);
      int n;
      n = 0;
      while ((busyOut || expBusyFn()) && n < bound) begin
         applyStimulus(1'b0, STAT, 32'd0);
         n++;
      end
      if (n >= bound) checkVal({name, "_timeout"}, 32'(n), 32'(bound - 1));
   endtask

   initial begin
      logic [9:0]  frameA5;
      logic [31:0] r;
      int          n;

      tbl[0] = '{1'b0, STAT,          32'h0,  1'b1, 1'b0, 32'h0000_0002};
      tbl[1] = '{1'b1, BASE + 32'd8,  32'h55, 1'b1, 1'b0, 32'h0000_0000};
      tbl[2] = '{1'b1, 32'h0000_0010, 32'h66, 1'b1, 1'b0, 32'h0000_0000};
      tbl[3] = '{1'b0, STAT,          32'h0,  1'b1, 1'b0, 32'h0000_0002};
      tbl[4] = '{1'b1, BASE,          32'hA5, 1'b1, 1'b1, 32'h0000_0000};
      tbl[5] = '{1'b0, STAT,          32'h0,  1'b0, 1'b1, 32'h0000_0006};
      tbl[6] = '{1'b0, STAT,          32'h0,  1'b0, 1'b1, 32'h0000_0006};
      tbl[7] = '{1'b0, STAT,          32'h0,  1'b0, 1'b1, 32'h0000_0006};

      busIf.mem_write = 1'b0;
      busIf.data_addr = STAT;
      busIf.wr_data   = 32'd0;
      modelClear();

      repeat (3) @(negedge clock);
      checkVal("reset_tx", {31'd0, txLine}, 32'd1);
      checkVal("reset_busy", {31'd0, busyOut}, 32'd0);
      checkVal("reset_status", busIf.rd_data, 32'h0000_0002);
      reset = 1'b1;

      // Reset state, address decoding and the start of a 0xA5 frame.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(tbl[i].we, tbl[i].addr, tbl[i].data);
         checkVal($sformatf("tbl%0d_tx", i), {31'd0, txLine}, {31'd0, tbl[i].expTx});
         checkVal($sformatf("tbl%0d_busy", i), {31'd0, busyOut}, {31'd0, tbl[i].expBusy});
         checkVal($sformatf("tbl%0d_rd", i), busIf.rd_data, tbl[i].expRd);
      end

      frameA5 = {1'b1, 8'hA5, 1'b0};
      for (int t = 3; t < FRAME; t++) begin
         applyStimulus(1'b0, STAT, 32'd0);
         checkVal("frameA5", {31'd0, txLine}, {31'd0, frameA5[t / CPB]});
      end
      applyStimulus(1'b0, STAT, 32'd0);
      checkVal("a5_busy_done", {31'd0, busyOut}, 32'd0);

      // Five queued bytes go out as one contiguous 200-cycle burst.
      applyStimulus(1'b1, BASE, 32'h01);
      n = 0;
      for (int i = 2; i <= 5; i++) begin
         applyStimulus(1'b1, BASE, 32'(i));
         n++;
      end
      while (busyOut && n < 400) begin
         applyStimulus(1'b0, STAT, 32'd0);
         n++;
      end
      checkVal("b2b_len", 32'(n), 32'd201);
      r = busIf.rd_data;
      checkVal("b2b_ovf", {24'd0, r[15:8]}, 32'd0);

      // Eight stores in a row drop three bytes; a STATUS write clears the count.
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, BASE, 32'($urandom_range(0, 255)));
      applyStimulus(1'b0, STAT, 32'd0);
      r = busIf.rd_data;
      checkVal("ovf3", {24'd0, r[15:8]}, 32'd3);
      applyStimulus(1'b1, STAT, 32'h1);
      r = busIf.rd_data;
      checkVal("ovf_clr", {24'd0, r[15:8]}, 32'd0);
      drain("ovf_drain", 600);

      // Reset asserted in the middle of the data bits of a 0x00 frame.
      applyStimulus(1'b1, BASE, 32'h00);
      idle(12);
      #2 reset = 1'b0;
      modelClear();
      #1;
      checkVal("mid_reset_tx", {31'd0, txLine}, 32'd1);
      checkVal("mid_reset_busy", {31'd0, busyOut}, 32'd0);
      checkVal("mid_reset_status", busIf.rd_data, 32'h0000_0002);
      @(negedge clock);
      checkOutput();
      reset = 1'b1;
      idle(60);
      checkVal("post_reset_busy", {31'd0, busyOut}, 32'd0);

      // Random bus traffic against the model.
      for (int i = 0; i < 2500; i++) begin
         int          sel;
         logic [31:0] addr;
         sel = $urandom_range(0, 19);
         if (sel < 3) begin
            applyStimulus(1'b1, BASE, $urandom);
         end else if (sel == 3) begin
            applyStimulus(1'b1, STAT, 32'($urandom_range(0, 3)));
         end else if (sel == 4) begin
            addr = $urandom;
            applyStimulus(1'b1, addr, $urandom);
         end else begin
            addr = (sel < 14) ? STAT : ((sel < 17) ? BASE : 32'h0000_0010);
            applyStimulus(1'b0, addr, $urandom);
         end
      end
      drain("rand_drain", 1000);
      checkVal("final_busy", {31'd0, busyOut}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
      $finish;
   end

endmodule
